// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter for the riscv core.
// The instruction-fetch (I) and load/store (D) buses share one memory port, with at
// most one transaction in flight. D has priority. After D_MAX_STREAK back-to-back D
// grants taken while I was waiting, the next grant goes to I. If the memory never
// answers, a response timeout returns an error to the requester.
module riscv_mem_arbiter #(
  parameter int unsigned D_MAX_STREAK = 4,
  parameter int unsigned RSP_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstf,
  // instruction fetch bus
  input  logic        i_cmd_valid,
  output logic        i_cmd_ready,
  input  logic [31:0] i_cmd_pc,
  output logic        i_rsp_valid,
  output logic        i_rsp_err,
  output logic [31:0] i_rsp_inst,
  // load/store bus
  input  logic        d_cmd_valid,
  output logic        d_cmd_ready,
  input  logic        d_cmd_wr,
  input  logic [31:0] d_cmd_address,
  input  logic [31:0] d_cmd_data,
  input  logic [1:0]  d_cmd_size,
  output logic        d_rsp_valid,
  output logic        d_rsp_err,
  output logic [31:0] d_rsp_data,
  // shared memory port
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic        m_cmd_wr,
  output logic [31:0] m_cmd_address,
  output logic [31:0] m_cmd_data,
  output logic [1:0]  m_cmd_size,
  input  logic        m_rsp_valid,
  input  logic        m_rsp_err,
  input  logic [31:0] m_rsp_data
);

  localparam int StreakW = (D_MAX_STREAK < 1) ? 1 : $clog2(D_MAX_STREAK + 1);
  localparam int TimerW  = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

  localparam logic [StreakW-1:0] StreakMax = StreakW'(D_MAX_STREAK);
  localparam logic [TimerW-1:0]  TimerLast = TimerW'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StRsp
  } state_e;

  state_e             state_q, state_d;
  logic               owner_is_d_q, owner_is_d_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [TimerW-1:0]  timer_q, timer_d;

  logic               cmd_valid_q, cmd_valid_d;
  logic               cmd_wr_q, cmd_wr_d;
  logic [31:0]        cmd_address_q, cmd_address_d;
  logic [31:0]        cmd_data_q, cmd_data_d;
  logic [1:0]         cmd_size_q, cmd_size_d;

  logic               i_rsp_valid_q, i_rsp_valid_d;
  logic               i_rsp_err_q, i_rsp_err_d;
  logic [31:0]        i_rsp_inst_q, i_rsp_inst_d;
  logic               d_rsp_valid_q, d_rsp_valid_d;
  logic               d_rsp_err_q, d_rsp_err_d;
  logic [31:0]        d_rsp_data_q, d_rsp_data_d;

  logic               grant_d;
  logic               grant_i;
  logic               deliver;
  logic               deliver_err;
  logic [31:0]        deliver_data;

  // Grant decision, only in IDLE. Gated with rstf so that no ready is seen during reset.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (rstf && (state_q == StIdle)) begin
      grant_d = d_cmd_valid && !(i_cmd_valid && (streak_q == StreakMax));
      grant_i = !grant_d && i_cmd_valid;
    end
  end

  assign d_cmd_ready = grant_d;
  assign i_cmd_ready = grant_i;

  // Next-state, command payload capture, streak/timer update and response steering.
  always_comb begin
    state_d       = state_q;
    owner_is_d_d  = owner_is_d_q;
    streak_d      = streak_q;
    timer_d       = timer_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_address_d = cmd_address_q;
    cmd_data_d    = cmd_data_q;
    cmd_size_d    = cmd_size_q;
    deliver       = 1'b0;
    deliver_err   = 1'b0;
    deliver_data  = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          cmd_valid_d   = 1'b1;
          cmd_wr_d      = d_cmd_wr;
          cmd_address_d = d_cmd_address;
          cmd_data_d    = d_cmd_data;
          cmd_size_d    = d_cmd_size;
          owner_is_d_d  = 1'b1;
          state_d       = StCmd;
          // Count only the D grants that made a waiting fetch wait longer.
          if (i_cmd_valid) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + StreakW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (grant_i) begin
          cmd_valid_d   = 1'b1;
          cmd_wr_d      = 1'b0;
          cmd_address_d = i_cmd_pc;
          cmd_data_d    = 32'h0;
          cmd_size_d    = 2'd2;
          owner_is_d_d  = 1'b0;
          streak_d      = '0;
          state_d       = StCmd;
        end
      end

      StCmd: begin
        if (m_cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = StRsp;
        end
      end

      StRsp: begin
        timer_d = timer_q + TimerW'(1);
        if (m_rsp_valid) begin
          deliver      = 1'b1;
          deliver_err  = m_rsp_err;
          deliver_data = m_rsp_data;
          state_d      = StIdle;
        end else if (timer_q == TimerLast) begin
          // Synthesised error so the core never waits forever.
          deliver      = 1'b1;
          deliver_err  = 1'b1;
          deliver_data = 32'h0;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Route a delivered response to the owner only; the other side keeps its last err/data.
  always_comb begin
    i_rsp_valid_d = 1'b0;
    i_rsp_err_d   = i_rsp_err_q;
    i_rsp_inst_d  = i_rsp_inst_q;
    d_rsp_valid_d = 1'b0;
    d_rsp_err_d   = d_rsp_err_q;
    d_rsp_data_d  = d_rsp_data_q;
    if (deliver) begin
      if (owner_is_d_q) begin
        d_rsp_valid_d = 1'b1;
        d_rsp_err_d   = deliver_err;
        d_rsp_data_d  = deliver_data;
      end else begin
        i_rsp_valid_d = 1'b1;
        i_rsp_err_d   = deliver_err;
        i_rsp_inst_d  = deliver_data;
      end
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q       <= StIdle;
      owner_is_d_q  <= 1'b0;
      streak_q      <= '0;
      timer_q       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_wr_q      <= 1'b0;
      cmd_address_q <= 32'h0;
      cmd_data_q    <= 32'h0;
      cmd_size_q    <= 2'd0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_rsp_inst_q  <= 32'h0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      owner_is_d_q  <= owner_is_d_d;
      streak_q      <= streak_d;
      timer_q       <= timer_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_address_q <= cmd_address_d;
      cmd_data_q    <= cmd_data_d;
      cmd_size_q    <= cmd_size_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_rsp_inst_q  <= i_rsp_inst_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign m_cmd_valid   = cmd_valid_q;
  assign m_cmd_wr      = cmd_wr_q;
  assign m_cmd_address = cmd_address_q;
  assign m_cmd_data    = cmd_data_q;
  assign m_cmd_size    = cmd_size_q;

  assign i_rsp_valid   = i_rsp_valid_q;
  assign i_rsp_err     = i_rsp_err_q;
  assign i_rsp_inst    = i_rsp_inst_q;
  assign d_rsp_valid   = d_rsp_valid_q;
  assign d_rsp_err     = d_rsp_err_q;
  assign d_rsp_data    = d_rsp_data_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus pushes expected memory commands and
// responses; monitors pop and compare whenever the DUT presents them.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstf;
  logic        i_cmd_valid, i_cmd_ready;
  logic [31:0] i_cmd_pc;
  logic        i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_inst;
  logic        d_cmd_valid, d_cmd_ready, d_cmd_wr;
  logic [31:0] d_cmd_address, d_cmd_data;
  logic [1:0]  d_cmd_size;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic        m_cmd_valid, m_cmd_ready, m_cmd_wr;
  logic [31:0] m_cmd_address, m_cmd_data;
  logic [1:0]  m_cmd_size;
  logic        m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_data;

  riscv_mem_arbiter #(
    .D_MAX_STREAK(4),
    .RSP_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rstf         (rstf),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd_ready  (i_cmd_ready),
    .i_cmd_pc     (i_cmd_pc),
    .i_rsp_valid  (i_rsp_valid),
    .i_rsp_err    (i_rsp_err),
    .i_rsp_inst   (i_rsp_inst),
    .d_cmd_valid  (d_cmd_valid),
    .d_cmd_ready  (d_cmd_ready),
    .d_cmd_wr     (d_cmd_wr),
    .d_cmd_address(d_cmd_address),
    .d_cmd_data   (d_cmd_data),
    .d_cmd_size   (d_cmd_size),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_err    (d_rsp_err),
    .d_rsp_data   (d_rsp_data),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .m_cmd_wr     (m_cmd_wr),
    .m_cmd_address(m_cmd_address),
    .m_cmd_data   (m_cmd_data),
    .m_cmd_size   (m_cmd_size),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_err    (m_rsp_err),
    .m_rsp_data   (m_rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } cmd_t;

  typedef struct packed {
    logic        side;  // 1 = D
    logic        err;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   last_rsp_cyc = 0;

  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s);
    cmd_q.push_back('{wr: wr, addr: a, data: d, size: s});
  endtask

  task automatic push_rsp(input logic side, input logic err, input logic [31:0] d);
    rsp_q.push_back('{side: side, err: err, data: d});
  endtask

  // Monitor: memory command handshakes and requester responses.
  always @(negedge clk) begin : monitor
    cmd_t ec;
    rsp_t er;
    if (m_cmd_valid && m_cmd_ready) begin
      if (cmd_q.size() == 0) begin
        total++;
        $display("FAIL cmd_unexpected: got addr %0h expected no command", m_cmd_address);
      end else begin
        ec = cmd_q.pop_front();
        check("m_cmd", {m_cmd_wr, m_cmd_address, m_cmd_data, m_cmd_size},
              {ec.wr, ec.addr, ec.data, ec.size});
      end
    end
    if (i_rsp_valid || d_rsp_valid) begin
      last_rsp_cyc = cyc;
      if (i_rsp_valid && d_rsp_valid) begin
        total++;
        $display("FAIL rsp_both: got i and d valid expected one");
      end else if (rsp_q.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got side %0d expected no response", d_rsp_valid);
      end else begin
        er = rsp_q.pop_front();
        check("rsp", {d_rsp_valid, d_rsp_valid ? d_rsp_err : i_rsp_err,
                      d_rsp_valid ? d_rsp_data : i_rsp_inst},
              {er.side, er.err, er.data});
      end
    end
  end

  // Memory model: answers one cycle after the accept cycle unless muted.
  logic mem_mute   = 1'b0;
  int   stray_req  = 0;
  int   stray_done = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], 16'hC0DE};
  endfunction

  initial begin : memory
    logic        hs;
    logic [31:0] a;
    m_rsp_valid = 1'b0;
    m_rsp_err   = 1'b0;
    m_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs = m_cmd_valid && m_cmd_ready && !mem_mute;
      a  = m_cmd_address;
      @(posedge clk);
      #1;
      if (hs) begin
        m_rsp_valid = 1'b1;
        m_rsp_err   = 1'b0;
        m_rsp_data  = mem_data(a);
      end else if (stray_req != stray_done) begin
        stray_done++;
        m_rsp_valid = 1'b1;
        m_rsp_err   = 1'b0;
        m_rsp_data  = 32'hBAD0_BAD0;
      end else begin
        m_rsp_valid = 1'b0;
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, output int t_acc);
    int k;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_pc    = pc;
    #1;
    k = 0;
    while (!i_cmd_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!i_cmd_ready) begin
      total++;
      $display("FAIL fetch_grant_timeout: got no ready expected grant for pc %0h", pc);
    end
    t_acc = cyc;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  // keep=1 leaves valid high after acceptance so the next call follows back-to-back.
  task automatic dreq(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic keep, output int t_acc);
    int k;
    @(negedge clk);
    d_cmd_valid   = 1'b1;
    d_cmd_wr      = wr;
    d_cmd_address = a;
    d_cmd_data    = d;
    d_cmd_size    = s;
    #1;
    k = 0;
    while (!d_cmd_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!d_cmd_ready) begin
      total++;
      $display("FAIL d_grant_timeout: got no ready expected grant for addr %0h", a);
    end
    t_acc = cyc;
    @(posedge clk);
    #1;
    if (!keep) d_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (rsp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() != 0) begin
      total++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, rsp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {i_cmd_ready, i_rsp_valid, i_rsp_err, d_cmd_ready, d_rsp_valid,
                            d_rsp_err, m_cmd_valid, m_cmd_wr, m_cmd_size, i_rsp_inst,
                            d_rsp_data}, '0);
    check({name, "_mcmd"}, {m_cmd_address, m_cmd_data}, '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t_i, t_d, t_x;
    rstf          = 1'b0;
    i_cmd_valid   = 1'b0;
    i_cmd_pc      = 32'h0;
    d_cmd_valid   = 1'b0;
    d_cmd_wr      = 1'b0;
    d_cmd_address = 32'h0;
    d_cmd_data    = 32'h0;
    d_cmd_size    = 2'd0;
    m_cmd_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstf = 1'b1;

    // 1: fetch only, minimum round trip of three cycles
    push_cmd(1'b0, 32'h100, 32'h0, 2'd2);
    push_rsp(1'b0, 1'b0, 32'h0050_0093);
    fetch(32'h100, t_i);
    drain("t1");
    check("t1_latency", last_rsp_cyc - t_i, 3);

    // 2: simultaneous I and D; D first, I granted in the IDLE cycle of D's response
    push_cmd(1'b1, 32'h2000, 32'hDEAD_BEEF, 2'd2);
    push_cmd(1'b0, 32'h104, 32'h0, 2'd2);
    push_rsp(1'b1, 1'b0, 32'h2000_C0DE);
    push_rsp(1'b0, 1'b0, 32'h0104_C0DE);
    fork
      fetch(32'h104, t_i);
      dreq(1'b1, 32'h2000, 32'hDEAD_BEEF, 2'd2, 1'b0, t_d);
    join
    drain("t2");
    check("t2_i_after_d", t_i - t_d, 3);

    // 3: both held high: D,D,D,D,I,D,D
    push_cmd(1'b0, 32'h3000, 32'h0, 2'd0);
    push_cmd(1'b0, 32'h3004, 32'h0, 2'd1);
    push_cmd(1'b0, 32'h3008, 32'h0, 2'd2);
    push_cmd(1'b0, 32'h300C, 32'h0, 2'd0);
    push_cmd(1'b0, 32'h200, 32'h0, 2'd2);
    push_cmd(1'b1, 32'h3010, 32'h1122_3344, 2'd2);
    push_cmd(1'b0, 32'h3014, 32'h0, 2'd1);
    push_rsp(1'b1, 1'b0, 32'h3000_C0DE);
    push_rsp(1'b1, 1'b0, 32'h3004_C0DE);
    push_rsp(1'b1, 1'b0, 32'h3008_C0DE);
    push_rsp(1'b1, 1'b0, 32'h300C_C0DE);
    push_rsp(1'b0, 1'b0, 32'h0200_C0DE);
    push_rsp(1'b1, 1'b0, 32'h3010_C0DE);
    push_rsp(1'b1, 1'b0, 32'h3014_C0DE);
    fork
      fetch(32'h200, t_i);
      begin
        dreq(1'b0, 32'h3000, 32'h0, 2'd0, 1'b1, t_x);
        dreq(1'b0, 32'h3004, 32'h0, 2'd1, 1'b1, t_x);
        dreq(1'b0, 32'h3008, 32'h0, 2'd2, 1'b1, t_x);
        dreq(1'b0, 32'h300C, 32'h0, 2'd0, 1'b1, t_x);
        dreq(1'b1, 32'h3010, 32'h1122_3344, 2'd2, 1'b1, t_x);
        dreq(1'b0, 32'h3014, 32'h0, 2'd1, 1'b0, t_x);
      end
    join
    drain("t3");

    // 4: memory stalls 10 cycles; command stays stable, no ready to a waiting D
    @(posedge clk);
    #1;
    m_cmd_ready = 1'b0;
    push_cmd(1'b0, 32'h300, 32'h0, 2'd2);
    push_cmd(1'b1, 32'h3100, 32'h55AA_55AA, 2'd1);
    push_rsp(1'b0, 1'b0, 32'h0300_C0DE);
    push_rsp(1'b1, 1'b0, 32'h3100_C0DE);
    fetch(32'h300, t_i);
    fork
      dreq(1'b1, 32'h3100, 32'h55AA_55AA, 2'd1, 1'b0, t_d);
      begin
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          #1;
          check("t4_hold", {m_cmd_valid, m_cmd_wr, m_cmd_address, m_cmd_data, m_cmd_size,
                            i_cmd_ready, d_cmd_ready},
                {1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        m_cmd_ready = 1'b1;
      end
    join
    drain("t4");

    // 5: no memory response -> error after 8 RSP cycles; a late response is dropped
    @(posedge clk);
    #1;
    mem_mute = 1'b1;
    push_cmd(1'b0, 32'h4000, 32'h0, 2'd2);
    push_rsp(1'b1, 1'b1, 32'h0);
    dreq(1'b0, 32'h4000, 32'h0, 2'd2, 1'b0, t_d);
    drain("t5");
    check("t5_latency", last_rsp_cyc - t_d, 10);
    stray_req++;
    repeat (4) @(negedge clk);
    check("t5_d_hold", {d_rsp_valid, d_rsp_err, d_rsp_data}, {1'b0, 1'b1, 32'h0});
    check("t5_i_hold", {i_rsp_valid, i_rsp_err, i_rsp_inst}, {1'b0, 1'b0, 32'h0300_C0DE});
    @(posedge clk);
    #1;
    mem_mute = 1'b0;

    // 6: reset while in RSP abandons the fetch; a later fetch proceeds normally
    @(posedge clk);
    #1;
    mem_mute = 1'b1;
    push_cmd(1'b0, 32'h500, 32'h0, 2'd2);
    fetch(32'h500, t_i);
    repeat (3) @(posedge clk);
    #3;
    rstf = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (2) @(negedge clk);
    rstf = 1'b1;
    @(posedge clk);
    #1;
    mem_mute = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_quiet", {i_rsp_valid, d_rsp_valid, m_cmd_valid}, 3'b000);
    push_cmd(1'b0, 32'h600, 32'h0, 2'd2);
    push_rsp(1'b0, 1'b0, 32'h0600_C0DE);
    fetch(32'h600, t_i);
    drain("t6");
    check("t6_latency", last_rsp_cyc - t_i, 3);

    repeat (3) @(negedge clk);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
